// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter for the peripheral local bus. It decodes the address to a
// one-hot slave select, runs one transaction at a time and releases the bus on a timeout.
module periph_bus_arbiter #(
  parameter int unsigned NSLV    = 4,
  parameter logic [3:0]  BASE_HI = 4'h1,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [31:0]     m0_addr,
  input  logic [31:0]     m0_wdata,
  input  logic [3:0]      m0_wmask,
  output logic            m0_ack,
  output logic            m0_err,
  output logic [31:0]     m0_rdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [31:0]     m1_addr,
  input  logic [31:0]     m1_wdata,
  input  logic [3:0]      m1_wmask,
  output logic            m1_ack,
  output logic            m1_err,
  output logic [31:0]     m1_rdata,
  output logic [NSLV-1:0] sel,
  output logic [31:0]     add_w,
  output logic [31:0]     data_w,
  output logic            wen,
  output logic [3:0]      wmask,
  input  logic            wready,
  output logic [31:0]     add_r,
  output logic            ren,
  input  logic [31:0]     data_r,
  input  logic            rvalid
);

  typedef enum logic [1:0] {StIdle, StWr, StRd, StResp} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic            gnt_q, gnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      lmask_q, lmask_d;
  logic [7:0]      cnt_q, cnt_d;

  logic [NSLV-1:0] sel_q, sel_d;
  logic [31:0]     add_w_q, add_w_d, data_w_q, data_w_d, add_r_q, add_r_d;
  logic            wen_q, wen_d, ren_q, ren_d;
  logic [3:0]      wmask_q, wmask_d;
  logic            m0_ack_q, m0_ack_d, m0_err_q, m0_err_d;
  logic            m1_ack_q, m1_ack_d, m1_err_q, m1_err_d;
  logic [31:0]     m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

  logic            pick;
  logic            req_we;
  logic [31:0]     req_addr;
  logic            resp_err;
  logic [31:0]     resp_rdata;
  logic            timeout;
  logic            bus_act;

  // The counter reaches TIMEOUT-1 at the edge ending the last allowed WR/RD cycle.
  assign timeout = (cnt_q == 8'(TIMEOUT - 2));

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lmask_d    = lmask_q;
    cnt_d      = cnt_q;
    resp_err   = 1'b0;
    resp_rdata = '0;
    pick       = (m0_req && m1_req) ? ~last_q : m1_req;
    req_we     = pick ? m1_we : m0_we;
    req_addr   = pick ? m1_addr : m0_addr;

    case (state_q)
      StIdle: begin
        if (m0_req || m1_req) begin
          gnt_d   = pick;
          last_d  = pick;
          addr_d  = req_addr;
          wdata_d = pick ? m1_wdata : m0_wdata;
          lmask_d = pick ? m1_wmask : m0_wmask;
          cnt_d   = '0;
          if (req_addr[31:28] != BASE_HI || 32'(req_addr[27:24]) >= NSLV) begin
            state_d  = StResp;
            resp_err = 1'b1;
          end else begin
            state_d = req_we ? StWr : StRd;
          end
        end
      end
      StWr: begin
        cnt_d = cnt_q + 8'd1;
        if (wready) begin
          state_d = StResp;
        end else if (timeout) begin
          state_d  = StResp;
          resp_err = 1'b1;
        end
      end
      StRd: begin
        cnt_d = cnt_q + 8'd1;
        if (rvalid) begin
          state_d    = StResp;
          resp_rdata = data_r;
        end else if (timeout) begin
          state_d  = StResp;
          resp_err = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    wen_d      = (state_d == StWr);
    ren_d      = (state_d == StRd);
    bus_act    = wen_d || ren_d;
    sel_d      = bus_act ? (NSLV'(1) << addr_d[27:24]) : '0;
    add_w_d    = wen_d ? {4'h0, addr_d[27:0]} : '0;
    data_w_d   = wen_d ? wdata_d : '0;
    wmask_d    = wen_d ? lmask_d : '0;
    add_r_d    = ren_d ? {4'h0, addr_d[27:0]} : '0;
    m0_ack_d   = (state_d == StResp) && !gnt_d;
    m1_ack_d   = (state_d == StResp) && gnt_d;
    m0_err_d   = m0_ack_d && resp_err;
    m1_err_d   = m1_ack_d && resp_err;
    m0_rdata_d = m0_ack_d ? resp_rdata : '0;
    m1_rdata_d = m1_ack_d ? resp_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lmask_q    <= '0;
      cnt_q      <= '0;
      sel_q      <= '0;
      add_w_q    <= '0;
      data_w_q   <= '0;
      wen_q      <= 1'b0;
      wmask_q    <= '0;
      add_r_q    <= '0;
      ren_q      <= 1'b0;
      m0_ack_q   <= 1'b0;
      m0_err_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_ack_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lmask_q    <= lmask_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      add_w_q    <= add_w_d;
      data_w_q   <= data_w_d;
      wen_q      <= wen_d;
      wmask_q    <= wmask_d;
      add_r_q    <= add_r_d;
      ren_q      <= ren_d;
      m0_ack_q   <= m0_ack_d;
      m0_err_q   <= m0_err_d;
      m0_rdata_q <= m0_rdata_d;
      m1_ack_q   <= m1_ack_d;
      m1_err_q   <= m1_err_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign sel      = sel_q;
  assign add_w    = add_w_q;
  assign data_w   = data_w_q;
  assign wen      = wen_q;
  assign wmask    = wmask_q;
  assign add_r    = add_r_q;
  assign ren      = ren_q;
  assign m0_ack   = m0_ack_q;
  assign m0_err   = m0_err_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_ack   = m1_ack_q;
  assign m1_err   = m1_err_q;
  assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Scoreboard bench for periph_bus_arbiter: expected responses are queued when a request is
// driven and compared by a monitor when an ack appears; strobe timing is checked inline.
module tb_periph_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [3:0]  m0_wmask = '0;
  logic        m0_ack, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m1_wmask = '0;
  logic        m1_ack, m1_err;
  logic [31:0] m1_rdata;
  logic [3:0]  sel;
  logic [31:0] add_w, data_w, add_r;
  logic        wen, ren;
  logic [3:0]  wmask;
  logic        wready = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] data_r = '0;

  always #5 clk = ~clk;

  periph_bus_arbiter #(.NSLV(4), .BASE_HI(4'h1), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wmask(m0_wmask), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wmask(m1_wmask), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .sel(sel), .add_w(add_w), .data_w(data_w), .wen(wen), .wmask(wmask), .wready(wready),
    .add_r(add_r), .ren(ren), .data_r(data_r), .rvalid(rvalid)
  );

  typedef struct packed {
    logic        m;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          total = 0;
  int          bad = 0;
  logic [173:0] outs;
  logic [33:0]  other;

  assign outs = {m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata, sel, add_w, data_w, wen,
                 wmask, add_r, ren};

  // Response monitor: every ack must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && (m0_ack || m1_ack)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_ack: m0_ack=%0b m1_ack=%0b, required no ack", m0_ack, m1_ack);
      end else begin
        e     = sb.pop_front();
        other = m1_ack ? {m0_ack, m0_err, m0_rdata} : {m1_ack, m1_err, m1_rdata};
        if ({m1_ack, m1_ack ? m1_err : m0_err, m1_ack ? m1_rdata : m0_rdata, other} !==
            {e.m, e.err, e.rdata, 34'h0}) begin
          bad++;
          $display("FAIL sb_resp: got m=%0b err=%0b rdata=%h other=%h, required m=%0b err=%0b rdata=%h other=0",
                   m1_ack, m1_ack ? m1_err : m0_err, m1_ack ? m1_rdata : m0_rdata, other,
                   e.m, e.err, e.rdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tick();
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_hold: outputs=%h, required 0", outs);
    end
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_release: outputs=%h, required 0", outs);
    end
  endtask

  task automatic test_write();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h1000_0004; m0_wdata = 32'hA5; m0_wmask = 4'hF;
    wready = 1'b1;
    sb.push_back('{1'b0, 1'b0, 32'h0});
    tick();
    total++;
    if ({wen, sel, add_w, data_w, wmask, ren, m0_ack, m1_ack} !==
        {1'b1, 4'b0001, 32'h4, 32'hA5, 4'hF, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL write_strobe: wen=%0b sel=%b add_w=%h data_w=%h wmask=%h ack=%0b, required 1 0001 00000004 000000a5 f 0",
               wen, sel, add_w, data_w, wmask, m0_ack);
    end
    tick();
    total++;
    if ({wen, sel, add_w, m0_ack} !== {1'b0, 4'b0, 32'h0, 1'b1}) begin
      bad++;
      $display("FAIL write_resp: wen=%0b sel=%b add_w=%h m0_ack=%0b, required 0 0000 0 1",
               wen, sel, add_w, m0_ack);
    end
    m0_req = 1'b0; wready = 1'b0;
    tick();
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL write_idle: outputs=%h, required 0", outs);
    end
  endtask

  task automatic test_read();
    int n;
    n = 0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h1200_0000;
    sb.push_back('{1'b1, 1'b0, 32'hDEAD_BEEF});
    for (int i = 0; i < 20 && !m1_ack; i++) begin
      tick();
      if (ren) begin
        n++;
        if (n == 1) begin
          total++;
          if ({sel, add_r, wen} !== {4'b0100, 32'h0200_0000, 1'b0}) begin
            bad++;
            $display("FAIL read_strobe: sel=%b add_r=%h wen=%0b, required 0100 02000000 0",
                     sel, add_r, wen);
          end
        end
      end
      rvalid = (n == 3) && ren;
      data_r = rvalid ? 32'hDEAD_BEEF : 32'h0;
    end
    total++;
    if ({n, m1_ack, ren} !== {32'd3, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL read_len: ren_cycles=%0d m1_ack=%0b ren=%0b, required 3 1 0", n, m1_ack, ren);
    end
    m1_req = 1'b0; rvalid = 1'b0; data_r = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int acks;
    acks = 0;
    apply_reset();
    wready = 1'b1; rvalid = 1'b1; data_r = 32'h1234_5678;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1000_0000;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h1100_0008; m1_wdata = 32'h55; m1_wmask = 4'h1;
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{1'b0, 1'b0, 32'h1234_5678});
      sb.push_back('{1'b1, 1'b0, 32'h0});
    end
    for (int i = 0; i < 40 && acks < 4; i++) begin
      tick();
      if (m0_ack || m1_ack) acks++;
      if (acks == 4) begin
        m0_req = 1'b0; m1_req = 1'b0;
      end
    end
    total++;
    if (acks != 4) begin
      bad++;
      $display("FAIL rr_count: acks=%0d, required 4", acks);
    end
    m0_req = 1'b0; m1_req = 1'b0; wready = 1'b0; rvalid = 1'b0; data_r = '0;
    tick();
    tick();
  endtask

  task automatic test_decode_err();
    logic [31:0] addrs[3];
    logic        ms[3];
    addrs[0] = 32'h2000_0000; ms[0] = 1'b0;
    addrs[1] = 32'h1700_0000; ms[1] = 1'b0;
    addrs[2] = 32'h1F00_0000; ms[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (ms[k]) begin
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = addrs[k];
      end else begin
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = addrs[k];
      end
      sb.push_back('{ms[k], 1'b1, 32'h0});
      tick();
      total++;
      if ({ms[k] ? m1_ack : m0_ack, ren, wen, sel} !== {1'b1, 1'b0, 1'b0, 4'b0}) begin
        bad++;
        $display("FAIL decode_err[%0d]: ack=%0b ren=%0b wen=%0b sel=%b, required 1 0 0 0000",
                 k, ms[k] ? m1_ack : m0_ack, ren, wen, sel);
      end
      m0_req = 1'b0; m1_req = 1'b0;
      tick();
    end
  endtask

  task automatic test_timeout();
    int n;
    for (int pass = 0; pass < 2; pass++) begin
      n = 0;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h1300_0010; m1_wdata = 32'hCAFE_0001;
      m1_wmask = 4'h3;
      sb.push_back('{1'b1, (pass == 0), 32'h0});
      for (int i = 0; i < 40 && !m1_ack; i++) begin
        tick();
        if (wen) begin
          n++;
          if (n == 1 && pass == 0) begin
            total++;
            if ({sel, add_w, data_w, wmask} !== {4'b1000, 32'h0300_0010, 32'hCAFE_0001, 4'h3}) begin
              bad++;
              $display("FAIL to_strobe: sel=%b add_w=%h data_w=%h wmask=%h, required 1000 03000010 cafe0001 3",
                       sel, add_w, data_w, wmask);
            end
          end
        end
        wready = (pass == 1) && (n == 15) && wen;
      end
      total++;
      if ({n, m1_ack} !== {32'd15, 1'b1}) begin
        bad++;
        $display("FAIL to_len[%0d]: wen_cycles=%0d m1_ack=%0b, required 15 1", pass, n, m1_ack);
      end
      m1_req = 1'b0; wready = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_abort();
    int acks;
    acks = 0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1100_0000; rvalid = 1'b0;
    tick();
    total++;
    if (ren !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre: ren=%0b, required 1", ren);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({ren, sel, add_r, m0_ack, m1_ack} !== '0) begin
      bad++;
      $display("FAIL abort_async: ren=%0b sel=%b add_r=%h ack=%0b%0b, required all 0",
               ren, sel, add_r, m0_ack, m1_ack);
    end
    m0_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL abort_release: outputs=%h, required 0", outs);
    end
    wready = 1'b1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h1000_0000;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h1100_0000;
    sb.push_back('{1'b0, 1'b0, 32'h0});
    sb.push_back('{1'b1, 1'b0, 32'h0});
    for (int i = 0; i < 20 && acks < 2; i++) begin
      tick();
      if (m0_ack) begin m0_req = 1'b0; acks++; end
      if (m1_ack) begin m1_req = 1'b0; acks++; end
    end
    total++;
    if (acks != 2) begin
      bad++;
      $display("FAIL abort_after: acks=%0d, required 2", acks);
    end
    m0_req = 1'b0; m1_req = 1'b0; wready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_decode_err();
    test_timeout();
    test_reset_abort();
    tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: pending=%0d, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
